// File: rtl/imc_wb_sequencer.sv
// Wishbone-side initiator for the SRAM IMC wrapper: writes the weight buffer and the
// activation vector, waits for the analog array, then reads back the 64-bit result.
module imc_wb_sequencer #(
    parameter int                     WIDTH_WB_DATA  = 32,
    parameter int                     WIDTH_ADD      = 32,
    parameter int                     MEM_ROW        = 16,
    parameter int                     SRAM_OUT_WIDTH = 16,
    parameter int                     IMC_OUT_WIDTH  = 64,
    parameter logic [WIDTH_ADD-1:0]   ROW_BASE_ADDR  = 32'h3000_0000,
    parameter logic [WIDTH_ADD-1:0]   IMC_TRIG_ADDR  = 32'h3000_0100,
    parameter logic [WIDTH_ADD-1:0]   IMC_RES_ADDR   = 32'h3000_0200,
    parameter int                     WR_CYCLES      = 4,
    parameter int                     IMC_CYCLES     = 8,
    parameter int                     RD_CYCLES      = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load_en,
    input  logic [$clog2(MEM_ROW)-1:0]   load_row,
    input  logic [SRAM_OUT_WIDTH-1:0]    load_data,
    input  logic [SRAM_OUT_WIDTH-1:0]    act_vec,
    input  logic                         start,
    input  logic                         imc_only,
    output logic                         wbs_we_o,
    output logic [WIDTH_ADD-1:0]         wb_addr_o,
    output logic [WIDTH_WB_DATA-1:0]     wb_data_o,
    input  logic [WIDTH_WB_DATA-1:0]     wb_data_i,
    output logic                         busy,
    output logic                         done,
    output logic [IMC_OUT_WIDTH-1:0]     imc_result
);

    localparam int ROW_W      = $clog2(MEM_ROW);
    localparam int CNT_MAX_A  = (WR_CYCLES > IMC_CYCLES) ? WR_CYCLES : IMC_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_A > RD_CYCLES) ? CNT_MAX_A : RD_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     WR_LAST   = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0]     IMC_LAST  = CNT_W'(IMC_CYCLES - 1);
    localparam logic [CNT_W-1:0]     RD_LAST   = CNT_W'(RD_CYCLES - 1);
    localparam logic [ROW_W-1:0]     ROW_ZERO  = ROW_W'(0);
    localparam logic [ROW_W-1:0]     ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0]     ROW_LAST  = ROW_W'(MEM_ROW - 1);
    localparam logic [WIDTH_ADD-1:0] RES_HI_ADDR = IMC_RES_ADDR + WIDTH_ADD'(32'd4);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ROW   = 3'd1,
        ST_IMC_TRIG = 3'd2,
        ST_IMC_WAIT = 3'd3,
        ST_RD_LO    = 3'd4,
        ST_RD_HI    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t                       state_r, state_nxt_s;
    logic [ROW_W-1:0]             row_r, row_nxt_s;
    logic [CNT_W-1:0]             cnt_r, cnt_nxt_s;
    logic [SRAM_OUT_WIDTH-1:0]    act_r, act_nxt_s;
    logic [SRAM_OUT_WIDTH-1:0]    wbuf_r [MEM_ROW];
    logic [SRAM_OUT_WIDTH-1:0]    row_data_s;

    logic                         we_nxt_s;
    logic [WIDTH_ADD-1:0]         addr_nxt_s;
    logic [WIDTH_WB_DATA-1:0]     data_nxt_s;
    logic                         busy_nxt_s;
    logic                         done_nxt_s;
    logic                         smp_lo_s;
    logic                         smp_hi_s;

    logic                         we_r;
    logic [WIDTH_ADD-1:0]         addr_r;
    logic [WIDTH_WB_DATA-1:0]     data_r;
    logic                         busy_r;
    logic                         done_r;
    logic [IMC_OUT_WIDTH-1:0]     result_r;

    // Next-state, row and cycle-counter logic of the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        cnt_nxt_s   = cnt_r;
        act_nxt_s   = act_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    act_nxt_s   = act_vec;
                    row_nxt_s   = ROW_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = imc_only ? ST_IMC_TRIG : ST_WR_ROW;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_ROW: begin
                if (cnt_r == WR_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (row_r == ROW_LAST) begin
                        state_nxt_s = ST_IMC_TRIG;
                    end else begin
                        row_nxt_s = row_r + ROW_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_IMC_TRIG: begin
                if (cnt_r == WR_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IMC_WAIT;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_IMC_WAIT: begin
                if (cnt_r == IMC_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_RD_LO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RD_LO: begin
                if (cnt_r == RD_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_RD_HI;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RD_HI: begin
                if (cnt_r == RD_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                row_nxt_s   = ROW_ZERO;
            end
        endcase
    end

    // Row value for the next write; a load landing in the start cycle is forwarded.
    always_comb begin
        if ((state_r == ST_IDLE) && load_en && (load_row == row_nxt_s)) begin
            row_data_s = load_data;
        end else begin
            row_data_s = wbuf_r[row_nxt_s];
        end
    end

    // Bus and status values for the upcoming state, registered below.
    always_comb begin
        we_nxt_s   = 1'b0;
        addr_nxt_s = '0;
        data_nxt_s = '0;
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_WR_ROW: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = ROW_BASE_ADDR + WIDTH_ADD'({row_nxt_s, 2'b00});
                data_nxt_s = WIDTH_WB_DATA'(row_data_s);
            end
            ST_IMC_TRIG: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = IMC_TRIG_ADDR;
                data_nxt_s = WIDTH_WB_DATA'(act_nxt_s);
            end
            ST_IMC_WAIT, ST_RD_LO: begin
                addr_nxt_s = IMC_RES_ADDR;
            end
            ST_RD_HI: begin
                addr_nxt_s = RES_HI_ADDR;
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Read data is captured on the final cycle each result address is held.
    always_comb begin
        smp_lo_s = (state_r == ST_RD_LO) && (cnt_r == RD_LAST);
        smp_hi_s = (state_r == ST_RD_HI) && (cnt_r == RD_LAST);
    end

    // State, counters, captured activation and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            row_r    <= ROW_ZERO;
            cnt_r    <= CNT_ZERO;
            act_r    <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            data_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            cnt_r   <= cnt_nxt_s;
            act_r   <= act_nxt_s;
            we_r    <= we_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            if (smp_lo_s) begin
                result_r[WIDTH_WB_DATA-1:0] <= wb_data_i;
            end
            if (smp_hi_s) begin
                result_r[IMC_OUT_WIDTH-1:WIDTH_WB_DATA] <= wb_data_i;
            end
        end
    end

    // Weight buffer: host writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_ROW; i++) begin
                wbuf_r[i] <= '0;
            end
        end else if ((state_r == ST_IDLE) && load_en) begin
            wbuf_r[load_row] <= load_data;
        end
    end

    assign wbs_we_o   = we_r;
    assign wb_addr_o  = addr_r;
    assign wb_data_o  = data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign imc_result = result_r;

endmodule
